stream_decipher: RTL and testbench
==================================

STREAM_DECIPHER -- requirements
Module: stream_decipher

Interface
REQ-001 The block SHALL have: clk  input  1  rising-edge clock.
REQ-002 The block SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL have: key_valid  input  1  load key this cycle.
REQ-004 The block SHALL have: key  input  8  initial counter block, sampled when key_valid=1.
REQ-005 The block SHALL have: ctxt_char  input  8  ciphertext character.
REQ-006 The block SHALL have: din_valid  input  1  ctxt_char valid.
REQ-007 The block SHALL have: din_ready  output  1  block accepts ctxt_char this cycle.
REQ-008 The block SHALL have: ptxt_char  output  8  recovered plaintext character.
REQ-009 The block SHALL have: dout_valid  output  1  ptxt_char valid.
REQ-010 The block SHALL have: dout_ready  input  1  sink accepts ptxt_char this cycle.
REQ-011 The block SHALL have: err  output  1  sticky flag: data offered before any key load.

Function
REQ-012 State machine SHALL have two states: IDLE (no key loaded) and RUN; reset enters IDLE.
REQ-013 key_valid=1 in any state SHALL load the 8-bit counter block cb <= key and move to RUN next cycle.
REQ-014 din_ready SHALL be combinational: (state==RUN) AND (buffer count < 2) AND NOT key_valid.
REQ-015 An input transfer SHALL occur only when din_valid=1 and din_ready=1.
REQ-016 On an input transfer, ctxt_char XOR sbox(cb) SHALL be written to the buffer tail, and cb SHALL advance.
REQ-017 cb advance SHALL be cb+1, with 255 wrapping to 0; cb SHALL be unchanged on cycles without a transfer.
REQ-018 Output SHALL use a 2-entry FIFO buffer; ptxt_char/dout_valid SHALL be driven from the head entry.
REQ-019 An output transfer SHALL occur when dout_valid=1 and dout_ready=1; the head entry is then popped.
REQ-020 Latency from input transfer to dout_valid SHALL be 1 cycle when the buffer is empty.
REQ-021 With dout_ready held high, throughput SHALL be 1 char/cycle with no bubbles.
REQ-022 Simultaneous push and pop SHALL leave the count unchanged; order SHALL be strictly FIFO.
REQ-023 When the buffer is full and not popped, din_ready SHALL be 0 and no character SHALL be lost or duplicated.
REQ-024 While dout_valid=1 and dout_ready=0, ptxt_char SHALL be held stable.
REQ-025 A key load in RUN SHALL NOT flush the buffer; buffered chars drain unchanged, and subsequent chars use the new cb.
REQ-026 key_valid and din_valid in the same cycle: the key SHALL win and the char SHALL NOT be accepted (din_ready=0).
REQ-027 din_valid=1 while in IDLE SHALL set err=1; err SHALL clear only on a key load or reset.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, cb=0, buffer empty, dout_valid=0, ptxt_char=0, err=0, din_ready=0.
REQ-029 Reset mid-stream SHALL discard all buffered characters; after release, no output SHALL appear until a key load and new input.

Structure
REQ-030 A shared package SHALL hold CHAR_W=8, BUF_DEPTH=2, the IDLE/RUN state enum, and the counter wrap constant 8'hFF.
REQ-031 The block SHALL instantiate the existing combinational sbox sub-module exactly once, on cb.
REQ-032 The decipher SHALL be an exact inverse of the existing stream cipher for the same key and character order.

Verification
REQ-033 Key 0x00 loaded, then ctxt 0x41 offered -> ptxt_char = 0x41 XOR SBOX[0x00] one cycle later, dout_valid=1.
REQ-034 Key 0xFE, 3 chars streamed, dout_ready=1 -> chars decrypted with SBOX[0xFE], SBOX[0xFF], SBOX[0x00] (wrap).
REQ-035 dout_ready=0 and 4 chars offered -> first 2 accepted, din_ready=0, then dout_ready=1 -> all 4 delivered in order.
REQ-036 din_valid=1 before any key -> err=1 and din_ready=0; key 0x10 loaded -> err=0 and the char is accepted using SBOX[0x10].
REQ-037 2 chars buffered under key 0x05, then key 0x80 loaded -> buffered outputs unchanged, next char uses SBOX[0x80].
REQ-038 rst_n pulsed low with 2 chars buffered -> dout_valid=0 immediately, state IDLE, and no stale output after release.

Source files
------------

// File: rtl/stream_decipher_pkg.sv
// Shared widths, buffer depth, FSM state type and counter-block helpers
// for the stream decipher slice.
package stream_decipher_pkg;

  localparam int CHAR_W    = 8;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  localparam logic [CHAR_W-1:0] CB_WRAP = 8'hFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The counter block wraps explicitly so the cipher and decipher agree on the rollover point.
  function automatic logic [CHAR_W-1:0] nextCb(input logic [CHAR_W-1:0] cb);
    return (cb == CB_WRAP) ? '0 : cb + CHAR_W'(1);
  endfunction

endpackage

// File: rtl/stream_decipher_sbox.sv
// Combinational byte substitution box (AES forward S-box) shared with the
// stream cipher; maps the counter block to the keystream byte.
module stream_decipher_sbox
  import stream_decipher_pkg::*;
(
  input  logic [CHAR_W-1:0] i_in,
  output logic [CHAR_W-1:0] o_out
);

  localparam logic [CHAR_W-1:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_out = SBOX_TABLE[i_in];

endmodule

// File: rtl/stream_decipher.sv
// Counter-mode stream decipher: XORs each ciphertext byte with sbox(cb),
// advances cb per accepted byte, and queues plaintext in a 2-entry FIFO.
module stream_decipher
  import stream_decipher_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [CHAR_W-1:0] key,
  input  logic [CHAR_W-1:0] ctxt_char,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [CHAR_W-1:0] ptxt_char,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              err
);

  state_e            r_state;
  logic [CHAR_W-1:0] r_cb;
  logic              r_err;
  logic [CHAR_W-1:0] r_mem [BUF_DEPTH];
  logic              r_wrPtr;
  logic              r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic [CHAR_W-1:0] w_keystream;
  logic              w_push;
  logic              w_pop;

  stream_decipher_sbox u_sbox (
    .i_in  (r_cb),
    .o_out (w_keystream)
  );

  // A key load blocks input for that cycle so the byte never pairs with a stale cb.
  assign din_ready  = (r_state == RUN) && (r_count < CNT_W'(BUF_DEPTH)) && !key_valid;
  assign dout_valid = (r_count != '0);
  assign ptxt_char  = dout_valid ? r_mem[r_rdPtr] : '0;
  assign err        = r_err;
  assign w_push     = din_valid && din_ready;
  assign w_pop      = dout_valid && dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cb    <= '0;
      r_err   <= 1'b0;
    end else if (key_valid) begin
      r_state <= RUN;
      r_cb    <= key;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_cb <= nextCb(r_cb);
      end
      if (din_valid && (r_state == IDLE)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Single-bit pointers simply toggle because the FIFO is exactly two entries deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= ctxt_char ^ w_keystream;
    end
  end

endmodule

// File: tb/tb_stream_decipher.sv
// Self-checking bench for stream_decipher: directed scenarios plus random traffic
// against a queue-based reference model with an S-box derived from GF(2^8) math.
module tb_stream_decipher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [7:0] key;
  logic [7:0] ctxt_char;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] ptxt_char;
  logic       dout_valid;
  logic       dout_ready;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [7:0] sboxTab [256];
  logic [7:0] mQ [$];
  logic [7:0] got [$];
  int         mCb;
  bit         mRun;
  bit         mErr;
  bit         lastPush;

  stream_decipher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key        (key),
    .ctxt_char  (ctxt_char),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ptxt_char  (ptxt_char),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Reference S-box from its definition: multiplicative inverse then affine transform.
  function automatic logic [7:0] aesSbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Checks outputs against the model mid-cycle, then advances model and DUT by one clock.
  task automatic applyStimulus(input string tag);
    bit expReady;
    bit push;
    bit pop;
    #1;
    expReady = mRun && (mQ.size() < 2) && !key_valid;
    checkOutput({tag, ".din_ready"}, {7'b0, din_ready}, {7'b0, expReady});
    checkOutput({tag, ".dout_valid"}, {7'b0, dout_valid}, {7'b0, mQ.size() != 0});
    checkOutput({tag, ".err"}, {7'b0, err}, {7'b0, mErr});
    if (mQ.size() != 0) checkOutput({tag, ".ptxt_char"}, ptxt_char, mQ[0]);
    if (dout_valid && dout_ready) got.push_back(ptxt_char);
    @(posedge clk);
    push = mRun && (mQ.size() < 2) && !key_valid && din_valid;
    pop  = (mQ.size() != 0) && dout_ready;
    if (pop) void'(mQ.pop_front());
    if (push) begin
      mQ.push_back(ctxt_char ^ sboxTab[mCb]);
      mCb = (mCb + 1) % 256;
    end
    if (key_valid) begin
      mCb  = int'(key);
      mRun = 1'b1;
      mErr = 1'b0;
    end else if (din_valid && !mRun) begin
      mErr = 1'b1;
    end
    lastPush = push;
    #1;
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, ".dout_valid"}, {7'b0, dout_valid}, 8'h00);
    checkOutput({tag, ".ptxt_char"}, ptxt_char, 8'h00);
    checkOutput({tag, ".err"}, {7'b0, err}, 8'h00);
    checkOutput({tag, ".din_ready"}, {7'b0, din_ready}, 8'h00);
    mQ.delete();
    mCb  = 0;
    mRun = 1'b0;
    mErr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic loadKey(input logic [7:0] k);
    key_valid = 1'b1;
    key       = k;
    din_valid = 1'b0;
    applyStimulus("key_load");
    key_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] c [4];
    int         idx;

    for (int i = 0; i < 256; i++) sboxTab[i] = aesSbox(8'(i));
    rst_n      = 1'b0;
    key_valid  = 1'b0;
    key        = 8'h00;
    ctxt_char  = 8'h00;
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    doReset("reset");

    // Data before any key sets err; the key wins over a simultaneous byte.
    din_valid = 1'b1;
    ctxt_char = 8'h5A;
    applyStimulus("idle_offer");
    checkOutput("req036_err_set", {7'b0, err}, 8'h01);
    key_valid = 1'b1;
    key       = 8'h10;
    applyStimulus("req036_key_wins");
    key_valid = 1'b0;
    checkOutput("req036_err_clr", {7'b0, err}, 8'h00);
    applyStimulus("req036_accept");
    checkOutput("req036_data", ptxt_char, 8'h5A ^ sboxTab[8'h10]);
    din_valid = 1'b0;
    applyStimulus("req036_drain");

    loadKey(8'h00);
    din_valid = 1'b1;
    ctxt_char = 8'h41;
    applyStimulus("req033_push");
    din_valid = 1'b0;
    checkOutput("req033_valid", {7'b0, dout_valid}, 8'h01);
    checkOutput("req033_data", ptxt_char, 8'h41 ^ sboxTab[8'h00]);
    applyStimulus("req033_drain");

    // Counter wrap from 0xFF back to 0x00 with full-rate streaming.
    loadKey(8'hFE);
    for (int i = 0; i < 3; i++) begin
      c[i]      = 8'($urandom);
      din_valid = 1'b1;
      ctxt_char = c[i];
      applyStimulus("req034_stream");
      checkOutput($sformatf("req034_char%0d", i), ptxt_char, c[i] ^ sboxTab[(254 + i) % 256]);
    end
    din_valid = 1'b0;
    applyStimulus("req034_drain");

    // Backpressure: only two bytes fit, then all four drain in order.
    loadKey(8'h20);
    dout_ready = 1'b0;
    got.delete();
    idx = 0;
    for (int i = 0; i < 4; i++) c[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b1;
      ctxt_char = c[idx];
      applyStimulus("req035_fill");
      if (lastPush) idx++;
    end
    checkOutput("req035_full_ready", {7'b0, din_ready}, 8'h00);
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din_valid = (idx < 4);
      ctxt_char = c[idx % 4];
      applyStimulus("req035_drain");
      if (lastPush) idx++;
    end
    checkOutput("req035_count", 8'(got.size()), 8'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("req035_order%0d", i), (i < got.size()) ? got[i] : 8'hxx,
                  c[i] ^ sboxTab[8'h20 + i]);
    end

    // Rekey with buffered data: old bytes drain unchanged, new byte uses the new key.
    loadKey(8'h05);
    dout_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 3; i++) c[i] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      din_valid = 1'b1;
      ctxt_char = c[i];
      applyStimulus("req037_fill");
    end
    loadKey(8'h80);
    dout_ready = 1'b1;
    din_valid  = 1'b0;
    applyStimulus("req037_pop0");
    din_valid = 1'b1;
    ctxt_char = c[2];
    applyStimulus("req037_push_new");
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus("req037_drain");
    checkOutput("req037_count", 8'(got.size()), 8'd3);
    checkOutput("req037_old0", (got.size() > 0) ? got[0] : 8'hxx, c[0] ^ sboxTab[8'h05]);
    checkOutput("req037_old1", (got.size() > 1) ? got[1] : 8'hxx, c[1] ^ sboxTab[8'h06]);
    checkOutput("req037_new", (got.size() > 2) ? got[2] : 8'hxx, c[2] ^ sboxTab[8'h80]);

    // Reset with a full buffer discards it; nothing appears afterwards without a key.
    loadKey(8'h33);
    dout_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din_valid = 1'b1;
      ctxt_char = 8'($urandom);
      applyStimulus("req038_fill");
    end
    doReset("req038_reset");
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus("req038_after");

    loadKey(8'($urandom));
    for (int i = 0; i < 400; i++) begin
      key_valid  = ($urandom_range(0, 19) == 0);
      key        = 8'($urandom);
      din_valid  = ($urandom_range(0, 3) != 0);
      ctxt_char  = 8'($urandom);
      dout_ready = ($urandom_range(0, 2) != 0);
      applyStimulus("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
